// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encodings and the default
// operand width used by the bit-serial units.
package arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/sub16_serial_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
interface sub16_serial_if
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] out;
    logic             borrow;
    logic             busy;
    logic             done;

    modport master (
        output start,
        output a,
        output b,
        input  out,
        input  borrow,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        output out,
        output borrow,
        output busy,
        output done
    );

endinterface

// File: rtl/sub16_serial_full_sub.sv
// One-bit full subtractor: x - y - bin, producing difference d and borrow-out.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    always_comb begin
        d    = x ^ y ^ bin;
        bout = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

// File: rtl/sub16_serial.sv
// Bit-serial a - b, LSB first through a single borrow flop; result bits enter
// the result register at the MSB so it is aligned after WIDTH shifts.
module sub16_serial
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    sub16_serial_if.slave bus
);

    localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] ra_q,     ra_d;
    logic [WIDTH-1:0] rb_q,     rb_d;
    logic [WIDTH-1:0] out_q,    out_d;
    logic             br_q,     br_d;
    logic             borrow_q, borrow_d;

    logic             diff_bit;
    logic             borrow_bit;
    logic             accept;

    full_sub u_full_sub (
        .x    (ra_q[0]),
        .y    (rb_q[0]),
        .bin  (br_q),
        .d    (diff_bit),
        .bout (borrow_bit)
    );

    // DONE accepts a new request just like IDLE, giving back-to-back operation.
    assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        out_d    = out_q;
        br_d     = br_q;
        borrow_d = borrow_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    ra_d    = bus.a;
                    rb_d    = bus.b;
                    out_d   = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                out_d = {diff_bit, out_q[WIDTH-1:1]};
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                br_d  = borrow_bit;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    borrow_d = borrow_bit;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ra_q     <= '0;
            rb_q     <= '0;
            out_q    <= '0;
            br_q     <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            out_q    <= out_d;
            br_q     <= br_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.out    = out_q;
    assign bus.borrow = borrow_q;
    assign bus.busy   = (state_q == S_BUSY);
    assign bus.done   = (state_q == S_DONE);

endmodule
